key_buffer_ctrl: RTL and testbench

Sequencer for the keypoint holding buffer between the FAST/orientation stage and the BRIEF descriptor stage.
- Tracks raster scan position and buffer occupancy.
- Issues push (o_flag) when a keypoint arrives and pop (o_hit) once the scan has passed the oldest keypoint's descriptor window.
- Drains the buffer at end of frame.
- Drives the buffer's flag/hit inputs directly and reads the buffer's head coordinates back.

---
 rtl/key_buffer_ctrl.sv | 199 +++++++++++++++++++
 tb/tb_key_buffer_ctrl.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/key_buffer_ctrl.sv
// Sequencer for the keypoint holding buffer between FAST/orientation and BRIEF.
// It tracks the raster position and buffer occupancy. It pushes arriving keypoints.
// It pops the oldest keypoint once its descriptor window has been fully scanned.
// At end of frame it drains whatever is left in the buffer.
module key_buffer_ctrl #(
   parameter int unsigned DEPTH      = 60,
   parameter int unsigned DELAY_ROWS = 15,
   parameter int unsigned IMG_W      = 640,
   parameter int unsigned IMG_H      = 480
) (
   input  logic        i_clk,
   input  logic        i_rst,
   input  logic        i_frame_start,
   input  logic        i_pix_valid,
   input  logic        i_key_valid,
   input  logic [9:0]  i_head_x,
   input  logic [9:0]  i_head_y,
   output logic        o_flag,
   output logic        o_hit,
   output logic [6:0]  o_occupancy,
   output logic [15:0] o_drop_cnt,
   output logic        o_frame_done,
   output logic        o_err
);

   localparam int unsigned XW = 10;
   localparam int unsigned YW = 10;
   localparam int unsigned OW = 7;
   localparam int unsigned DW = 16;
   localparam int unsigned CW = 11;

   localparam logic [XW-1:0] X_LAST  = XW'(IMG_W - 1);
   localparam logic [YW-1:0] Y_LAST  = YW'(IMG_H - 1);
   localparam logic [OW-1:0] OCC_MAX = OW'(DEPTH);
   localparam logic [CW-1:0] DELAY   = CW'(DELAY_ROWS);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_RUN   = 2'd1,
      ST_FLUSH = 2'd2,
      ST_DONE  = 2'd3
   } state_t;

   state_t          state_q,  state_d;
   logic [XW-1:0]   cur_x_q,  cur_x_d;
   logic [YW-1:0]   cur_y_q,  cur_y_d;
   logic            settle_q, settle_d;
   logic            flag_q,   flag_d;
   logic            hit_q,    hit_d;
   logic [OW-1:0]   occ_q,    occ_d;
   logic [DW-1:0]   drop_q,   drop_d;
   logic            done_q,   done_d;
   logic            err_q,    err_d;

   logic [XW-1:0]   nxt_x_c;
   logic [YW-1:0]   nxt_y_c;
   logic            last_pix_c;
   logic [CW-1:0]   due_y_c;
   logic [CW-1:0]   cur_y_ext_c;
   logic            win_c;
   logic            pop_c;
   logic            push_c;

   // Raster position following the current one; wraps to (0,0) after the last pixel
   always_comb begin
      nxt_x_c    = cur_x_q + XW'(1);
      nxt_y_c    = cur_y_q;
      last_pix_c = (cur_x_q == X_LAST) && (cur_y_q == Y_LAST);
      if (cur_x_q == X_LAST) begin
         nxt_x_c = '0;
         nxt_y_c = (cur_y_q == Y_LAST) ? '0 : cur_y_q + YW'(1);
      end
   end

   // Head descriptor window complete: scan is at or past (head_x, head_y + DELAY_ROWS)
   always_comb begin
      due_y_c     = CW'(i_head_y) + DELAY;
      cur_y_ext_c = CW'(cur_y_q);
      win_c       = (cur_y_ext_c > due_y_c) ||
                    ((cur_y_ext_c == due_y_c) && (cur_x_q >= i_head_x));
   end

   // Next-state, push/pop decisions and registered output values
   always_comb begin
      state_d  = state_q;
      cur_x_d  = cur_x_q;
      cur_y_d  = cur_y_q;
      occ_d    = occ_q;
      drop_d   = drop_q;
      err_d    = err_q;
      done_d   = 1'b0;
      pop_c    = 1'b0;
      push_c   = 1'b0;

      case (state_q)
         ST_IDLE: begin
            // Start pixel is (0,0) and is consumed here; counters sit at (0,0) in IDLE
            if (i_frame_start && i_pix_valid) begin
               state_d = ST_RUN;
               cur_x_d = nxt_x_c;
               cur_y_d = nxt_y_c;
               drop_d  = '0;
            end
         end

         ST_RUN: begin
            if (i_frame_start) begin
               err_d = 1'b1;
            end
            pop_c = (occ_q != '0) && !settle_q && win_c;
            if (i_pix_valid) begin
               if (i_key_valid) begin
                  if ((occ_q < OCC_MAX) || pop_c) begin
                     push_c = 1'b1;
                  end else if (drop_q != '1) begin
                     drop_d = drop_q + DW'(1);
                  end
               end
               cur_x_d = nxt_x_c;
               cur_y_d = nxt_y_c;
               if (last_pix_c) begin
                  state_d = ST_FLUSH;
               end
            end
         end

         ST_FLUSH: begin
            if (i_frame_start) begin
               err_d = 1'b1;
            end
            // Drain one entry per two cycles; finish once empty and the last pop has settled
            if (!settle_q) begin
               if (occ_q != '0) begin
                  pop_c = 1'b1;
               end else begin
                  state_d = ST_DONE;
                  done_d  = 1'b1;
               end
            end
         end

         ST_DONE: begin
            if (i_frame_start) begin
               err_d = 1'b1;
            end
            state_d = ST_IDLE;
         end

         default: begin
            state_d = ST_IDLE;
         end
      endcase

      flag_d   = push_c;
      hit_d    = pop_c;
      settle_d = pop_c;

      if (push_c && !pop_c) begin
         occ_d = occ_q + OW'(1);
      end else if (pop_c && !push_c) begin
         occ_d = occ_q - OW'(1);
      end
   end

   // State and output registers
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         state_q  <= ST_IDLE;
         cur_x_q  <= '0;
         cur_y_q  <= '0;
         settle_q <= 1'b0;
         flag_q   <= 1'b0;
         hit_q    <= 1'b0;
         occ_q    <= '0;
         drop_q   <= '0;
         done_q   <= 1'b0;
         err_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         cur_x_q  <= cur_x_d;
         cur_y_q  <= cur_y_d;
         settle_q <= settle_d;
         flag_q   <= flag_d;
         hit_q    <= hit_d;
         occ_q    <= occ_d;
         drop_q   <= drop_d;
         done_q   <= done_d;
         err_q    <= err_d;
      end
   end

   assign o_flag       = flag_q;
   assign o_hit        = hit_q;
   assign o_occupancy  = occ_q;
   assign o_drop_cnt   = drop_q;
   assign o_frame_done = done_q;
   assign o_err        = err_q;

endmodule

// File: tb/tb_key_buffer_ctrl.sv
// Testbench for key_buffer_ctrl. It models the holding buffer around the DUT.
// A transaction-level reference predicts every strobe into a scoreboard queue.
`timescale 1ns/1ps
module tb_key_buffer_ctrl;

   localparam int DEPTH      = 60;
   localparam int DELAY_ROWS = 15;
   localparam int IMG_W      = 40;
   localparam int IMG_H      = 30;
   localparam int NPIX       = IMG_W * IMG_H;

   localparam int M_IDLE  = 0;
   localparam int M_RUN   = 1;
   localparam int M_FLUSH = 2;
   localparam int M_DONE  = 3;

   logic        clk = 1'b0;
   logic        i_rst = 1'b1;
   logic        i_frame_start = 1'b0;
   logic        i_pix_valid = 1'b0;
   logic        i_key_valid = 1'b0;
   logic [9:0]  head_x;
   logic [9:0]  head_y;
   logic        o_flag;
   logic        o_hit;
   logic [6:0]  o_occupancy;
   logic [15:0] o_drop_cnt;
   logic        o_frame_done;
   logic        o_err;

   key_buffer_ctrl #(
      .DEPTH(DEPTH), .DELAY_ROWS(DELAY_ROWS), .IMG_W(IMG_W), .IMG_H(IMG_H)
   ) dut (
      .i_clk(clk), .i_rst(i_rst), .i_frame_start(i_frame_start),
      .i_pix_valid(i_pix_valid), .i_key_valid(i_key_valid),
      .i_head_x(head_x), .i_head_y(head_y),
      .o_flag(o_flag), .o_hit(o_hit), .o_occupancy(o_occupancy),
      .o_drop_cnt(o_drop_cnt), .o_frame_done(o_frame_done), .o_err(o_err)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int n_checks = 0;
   int n_errors = 0;

   // Holding buffer: push coordinates of the key seen one cycle before o_flag
   typedef struct packed { logic [9:0] x; logic [9:0] y; } ent_t;
   ent_t       bufq[$];
   ent_t       prev_key;
   logic [9:0] drv_x = '0;
   logic [9:0] drv_y = '0;

   always @(posedge clk or posedge i_rst) begin
      if (i_rst) begin
         bufq.delete();
         head_x <= 10'h3FF;
         head_y <= 10'h3FF;
      end else begin
         if (o_hit && bufq.size() > 0) void'(bufq.pop_front());
         if (o_flag) bufq.push_back(prev_key);
         prev_key = {drv_x, drv_y};
         if (bufq.size() > 0) begin
            head_x <= bufq[0].x;
            head_y <= bufq[0].y;
         end else begin
            head_x <= 10'h3FF;
            head_y <= 10'h3FF;
         end
      end
   end

   // Scoreboard entries: one per cycle in which any strobe is expected
   typedef struct {
      int cyc;
      bit flag;
      bit hit;
      bit done;
      int occ;
      int drop;
   } exp_t;
   exp_t exp_q[$];

   // Reference model: keys held as linear raster indices, in arrival order
   int m_st = M_IDLE;
   int m_pos = 0;
   int m_keys[$];
   bit m_settle = 1'b0;
   int m_drop = 0;
   bit m_err = 1'b0;
   int dir_keys[$];

   task automatic model_reset();
      m_st = M_IDLE; m_pos = 0; m_keys.delete(); m_settle = 1'b0; m_drop = 0; m_err = 1'b0;
   endtask

   task automatic model_step(input bit fs, input bit pv, input bit kv);
      bit push = 1'b0;
      bit pop = 1'b0;
      bit done = 1'b0;
      int key_pos = 0;
      case (m_st)
         M_IDLE: begin
            if (fs && pv) begin m_st = M_RUN; m_pos = 1; m_drop = 0; end
         end
         M_RUN: begin
            if (fs) m_err = 1'b1;
            // Oldest key is due once the scan reaches the same column DELAY_ROWS rows later
            if (m_keys.size() > 0 && !m_settle)
               pop = (m_pos >= m_keys[0] + DELAY_ROWS * IMG_W);
            if (pv) begin
               if (kv) begin
                  if (m_keys.size() < DEPTH || pop) push = 1'b1;
                  else if (m_drop < 65535) m_drop++;
               end
               key_pos = m_pos;
               m_pos++;
               if (m_pos == NPIX) begin m_st = M_FLUSH; m_pos = 0; end
            end
         end
         M_FLUSH: begin
            if (fs) m_err = 1'b1;
            if (!m_settle) begin
               if (m_keys.size() > 0) pop = 1'b1;
               else begin done = 1'b1; m_st = M_DONE; end
            end
         end
         default: begin
            if (fs) m_err = 1'b1;
            m_st = M_IDLE;
         end
      endcase
      if (pop) void'(m_keys.pop_front());
      if (push) m_keys.push_back(key_pos);
      m_settle = pop;
      if (push || pop || done)
         exp_q.push_back('{cyc + 1, push, pop, done, m_keys.size(), m_drop});
   endtask

   // Drive one cycle of inputs at the falling edge and advance the model
   task automatic step(input bit fs, input bit pv, input bit kv);
      @(negedge clk);
      drv_x = 10'(m_pos % IMG_W);
      drv_y = 10'(m_pos / IMG_W);
      i_frame_start = fs;
      i_pix_valid = pv;
      i_key_valid = kv;
      model_step(fs, pv, kv);
   endtask

   task automatic check_val(input string name, input int act, input int req);
      n_checks++;
      if (act != req) begin
         n_errors++;
         $display("FAIL %s: got %0d, required %0d", name, act, req);
      end
   endtask

   task automatic check_zero(input string name);
      n_checks++;
      if ({o_flag, o_hit, o_frame_done, o_err, o_occupancy, o_drop_cnt} != '0) begin
         n_errors++;
         $display("FAIL %s: flag=%0b hit=%0b done=%0b err=%0b occ=%0d drop=%0d, required all 0",
                  name, o_flag, o_hit, o_frame_done, o_err, o_occupancy, o_drop_cnt);
      end
   endtask

   function automatic bit in_dir(input int pos);
      foreach (dir_keys[i]) if (dir_keys[i] == pos) return 1'b1;
      return 1'b0;
   endfunction

   // Scan one frame; directed mode places keys only at dir_keys positions
   task automatic run_frame(input int key_pct, input int pv_pct, input int err_at, input bit directed);
      int guard = 0;
      step(1'b1, 1'b1, 1'b0);
      while (m_st == M_RUN && guard < 20000) begin
         bit pv = ($urandom_range(99) < pv_pct);
         bit kv = directed ? in_dir(m_pos) : ($urandom_range(99) < key_pct);
         step(m_pos == err_at, pv, kv);
         guard++;
      end
   endtask

   task automatic drain(input string tag);
      int guard = 0;
      while (m_st != M_IDLE && guard < 2000) begin
         step(1'b0, $urandom_range(1) == 1, $urandom_range(1) == 1);
         guard++;
      end
      step(1'b0, 1'b0, 1'b0);
      step(1'b0, 1'b0, 1'b0);
      check_val({tag, "_drop_cnt"}, int'(o_drop_cnt), m_drop);
      check_val({tag, "_err"}, int'(o_err), int'(m_err));
      check_val({tag, "_occupancy"}, int'(o_occupancy), 0);
   endtask

   // Monitor: compare every presented strobe against the oldest expected entry
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         while (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
            n_checks++;
            n_errors++;
            $display("FAIL missed_strobe: nothing at cycle %0d, required flag=%0b hit=%0b done=%0b",
                     exp_q[0].cyc, exp_q[0].flag, exp_q[0].hit, exp_q[0].done);
            void'(exp_q.pop_front());
         end
         if (o_flag || o_hit || o_frame_done) begin
            n_checks++;
            if (exp_q.size() == 0 || exp_q[0].cyc != cyc) begin
               n_errors++;
               $display("FAIL unexpected_strobe: cycle %0d got flag=%0b hit=%0b done=%0b occ=%0d, required none",
                        cyc, o_flag, o_hit, o_frame_done, o_occupancy);
            end else begin
               e = exp_q.pop_front();
               if (o_flag != e.flag || o_hit != e.hit || o_frame_done != e.done ||
                   int'(o_occupancy) != e.occ || int'(o_drop_cnt) != e.drop) begin
                  n_errors++;
                  $display("FAIL strobe: cycle %0d got flag=%0b hit=%0b done=%0b occ=%0d drop=%0d, required flag=%0b hit=%0b done=%0b occ=%0d drop=%0d",
                           cyc, o_flag, o_hit, o_frame_done, o_occupancy, o_drop_cnt,
                           e.flag, e.hit, e.done, e.occ, e.drop);
               end
            end
         end
      end
   end

   initial begin
      repeat (3) @(negedge clk);
      check_zero("reset_state");
      #1 i_rst = 1'b0;
      model_reset();

      // Isolated key, adjacent pair, and three keys left for the drain
      dir_keys = '{3*IMG_W + 10, 5*IMG_W + 5, 5*IMG_W + 6, 28*IMG_W + 3, 29*IMG_W + 0, NPIX - 1};
      run_frame(0, 100, -1, 1'b1);
      drain("directed");

      // Dense keys overflow the buffer before the first window completes
      run_frame(20, 100, -1, 1'b0);
      drain("dense");

      run_frame(25, 70, -1, 1'b0);
      drain("gappy");

      // Frame start mid-scan, then reset while draining
      run_frame(10, 85, 300, 1'b0);
      step(1'b0, 1'b0, 1'b0);
      step(1'b0, 1'b0, 1'b0);
      check_val("err_sticky", int'(o_err), int'(m_err));
      check_val("flush_occupancy", int'(o_occupancy), m_keys.size());
      @(negedge clk);
      #1;
      exp_q.delete();
      i_frame_start = 1'b0; i_pix_valid = 1'b0; i_key_valid = 1'b0;
      i_rst = 1'b1;
      model_reset();
      @(negedge clk);
      check_zero("reset_mid_flush");
      #1 i_rst = 1'b0;

      run_frame(15, 90, -1, 1'b0);
      drain("after_reset");

      repeat (4) step(1'b0, 1'b0, 1'b0);
      check_val("scoreboard_empty", exp_q.size(), 0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
